dmac_rd_arbiter: RTL and testbench

//  Read-side AXI arbiter between the DMAC channel engines and the single AXI AR/R master port.

---
 rtl/dmac_rd_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmac_rd_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_rd_arbiter.sv
// Read-side AXI arbiter: round-robin grant of DMA channel read requests onto a single
// registered AR slot, and rid-based routing of returning R beats back to the owning channel.
module dmac_rd_arbiter #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ch_arvalid_i,
    input  logic [N_CH*ADDR_W-1:0]   ch_araddr_i,
    input  logic [N_CH*4-1:0]        ch_arlen_i,
    output logic [N_CH-1:0]          ch_arready_o,
    output logic [N_CH-1:0]          ch_rvalid_o,
    input  logic [N_CH-1:0]          ch_rready_i,
    output logic [DATA_W-1:0]        ch_rdata_o,
    output logic [1:0]               ch_rresp_o,
    output logic                     ch_rlast_o,
    output logic [ID_W-1:0]          arid_o,
    output logic [ADDR_W-1:0]        araddr_o,
    output logic [3:0]               arlen_o,
    output logic [2:0]               arsize_o,
    output logic [1:0]               arburst_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    input  logic [ID_W-1:0]          rid_i,
    input  logic [DATA_W-1:0]        rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     rlast_i,
    input  logic                     rvalid_i,
    output logic                     rready_o,
    output logic                     id_err_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]   busy_r;
    logic              arvalid_r;
    logic [ID_W-1:0]   arid_r;
    logic [ADDR_W-1:0] araddr_r;
    logic [3:0]        arlen_r;
    logic [CH_W-1:0]   rr_ptr_r;
    logic              id_err_r;

    logic [N_CH-1:0]   eligible_s;
    logic              slot_free_s;
    logic [CH_W:0]     pick_s;
    logic              grant_s;
    logic [CH_W-1:0]   win_s;
    logic [CH_W-1:0]   rr_next_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [3:0]        win_len_s;
    logic [N_CH-1:0]   ch_arready_s;
    logic              rid_ok_s;
    logic [N_CH-1:0]   ch_rvalid_s;
    logic              rready_s;
    logic              ar_hs_s;
    logic              r_last_hs_s;

    // First set bit of elig scanning ptr, ptr+1, ... (mod N_CH); MSB flags that one was found.
    function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] elig,
                                              input logic [CH_W-1:0] ptr);
        logic [CH_W:0] res;
        logic [CH_W:0] pos;
        res = {(CH_W+1){1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (CH_W+1)'(i);
            if (pos >= (CH_W+1)'(N_CH)) begin
                pos = pos - (CH_W+1)'(N_CH);
            end else begin
                pos = pos;
            end
            if (elig[pos[CH_W-1:0]]) begin
                res = {1'b1, pos[CH_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Request eligibility, round-robin winner selection and winner field mux.
    always_comb begin
        eligible_s   = {N_CH{1'b0}};
        ch_arready_s = {N_CH{1'b0}};
        win_addr_s   = {ADDR_W{1'b0}};
        win_len_s    = 4'd0;
        for (int k = 0; k < N_CH; k++) begin
            eligible_s[k] = ch_arvalid_i[k] & ~busy_r[k]
                          & ~(arvalid_r & (arid_r == ID_W'(k)));
        end
        slot_free_s = ~arvalid_r | arready_i;
        pick_s      = rr_pick(eligible_s, rr_ptr_r);
        win_s       = pick_s[CH_W-1:0];
        grant_s     = slot_free_s & pick_s[CH_W] & ~rst_n;
        for (int k = 0; k < N_CH; k++) begin
            if (win_s == CH_W'(k)) begin
                win_addr_s      = ch_araddr_i[k*ADDR_W +: ADDR_W];
                win_len_s       = ch_arlen_i[k*4 +: 4];
                ch_arready_s[k] = grant_s;
            end else begin
                ch_arready_s[k] = 1'b0;
            end
        end
        if (win_s == CH_W'(N_CH - 1)) begin
            rr_next_s = {CH_W{1'b0}};
        end else begin
            rr_next_s = win_s + CH_W'(1);
        end
    end

    // R routing by rid; beats with an out-of-range rid are accepted and dropped.
    always_comb begin
        ch_rvalid_s = {N_CH{1'b0}};
        rready_s    = 1'b0;
        // Compare one bit wider so 2**ID_W == N_CH does not truncate the bound.
        rid_ok_s    = ({1'b0, rid_i} < (ID_W+1)'(N_CH));
        for (int k = 0; k < N_CH; k++) begin
            ch_rvalid_s[k] = ~rst_n & rvalid_i & rid_ok_s & (rid_i == ID_W'(k));
            rready_s       = rready_s | ((rid_i == ID_W'(k)) & ch_rready_i[k]);
        end
        if (rst_n) begin
            rready_s = 1'b0;
        end else if (!rid_ok_s) begin
            rready_s = 1'b1;
        end else begin
            rready_s = rready_s;
        end
        ar_hs_s     = arvalid_r & arready_i;
        r_last_hs_s = rvalid_i & rready_s & rid_ok_s & rlast_i;
    end

    // AR slot, per-channel outstanding flags, round-robin pointer and sticky id error.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy_r    <= {N_CH{1'b0}};
            arvalid_r <= 1'b0;
            arid_r    <= {ID_W{1'b0}};
            araddr_r  <= {ADDR_W{1'b0}};
            arlen_r   <= 4'd0;
            rr_ptr_r  <= {CH_W{1'b0}};
            id_err_r  <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ar_hs_s && (arid_r == ID_W'(k))) begin
                    busy_r[k] <= 1'b1;
                end else if (r_last_hs_s && (rid_i == ID_W'(k))) begin
                    busy_r[k] <= 1'b0;
                end else begin
                    busy_r[k] <= busy_r[k];
                end
            end
            if (grant_s) begin
                arvalid_r <= 1'b1;
                arid_r    <= ID_W'(win_s);
                araddr_r  <= win_addr_s;
                arlen_r   <= win_len_s;
                rr_ptr_r  <= rr_next_s;
            end else if (slot_free_s) begin
                arvalid_r <= 1'b0;
            end else begin
                arvalid_r <= arvalid_r;
            end
            if (rvalid_i && !rid_ok_s) begin
                id_err_r <= 1'b1;
            end else begin
                id_err_r <= id_err_r;
            end
        end
    end

    assign ch_arready_o = ch_arready_s;
    assign ch_rvalid_o  = ch_rvalid_s;
    assign rready_o     = rready_s;
    assign ch_rdata_o   = rdata_i;
    assign ch_rresp_o   = rresp_i;
    assign ch_rlast_o   = rlast_i;
    assign arid_o       = arid_r;
    assign araddr_o     = araddr_r;
    assign arlen_o      = arlen_r;
    assign arsize_o     = 3'b010;
    assign arburst_o    = 2'b01;
    assign arvalid_o    = arvalid_r;
    assign id_err_o     = id_err_r;

endmodule

// File: tb/tb_dmac_rd_arbiter.sv
// Randomized bench for dmac_rd_arbiter: a queue/array-level model of grants, outstanding
// bursts and R routing is compared against the DUT every cycle, plus directed scenarios.
module tb_dmac_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      ch_arvalid;
    logic [N*AW-1:0]   ch_araddr;
    logic [N*4-1:0]    ch_arlen;
    logic [N-1:0]      ch_rready;
    logic              arready;
    logic [IW-1:0]     rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;

    logic [N-1:0]      ch_arready_o;
    logic [N-1:0]      ch_rvalid_o;
    logic [DW-1:0]     ch_rdata_o;
    logic [1:0]        ch_rresp_o;
    logic              ch_rlast_o;
    logic [IW-1:0]     arid_o;
    logic [AW-1:0]     araddr_o;
    logic [3:0]        arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;
    logic              arvalid_o;
    logic              rready_o;
    logic              id_err_o;

    dmac_rd_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_arvalid_i(ch_arvalid), .ch_araddr_i(ch_araddr), .ch_arlen_i(ch_arlen),
        .ch_arready_o(ch_arready_o), .ch_rvalid_o(ch_rvalid_o), .ch_rready_i(ch_rready),
        .ch_rdata_o(ch_rdata_o), .ch_rresp_o(ch_rresp_o), .ch_rlast_o(ch_rlast_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
        .rready_o(rready_o), .id_err_o(id_err_o)
    );

    int checks   = 0;
    int failures = 0;

    // model state
    bit           m_busy [N];
    bit           m_sv;
    int           m_sid;
    logic [AW-1:0] m_saddr;
    logic [3:0]   m_slen;
    int           m_rr;
    bit           m_err;
    int           rem [N];

    // stimulus knobs (percent probabilities)
    int p_req = 50, p_arready = 50, p_rvalid = 50, p_rready = 50, p_bad = 0, p_lenmax = 3;
    bit r_rand = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_busy[k] = 1'b0;
            rem[k]    = 0;
        end
        m_sv = 1'b0; m_sid = 0; m_saddr = '0; m_slen = 4'd0; m_rr = 0; m_err = 1'b0;
    endtask

    task automatic slave_drive();
        int start, c, pick;
        pick  = -1;
        start = r_rand ? int'($urandom_range(0, N - 1)) : 0;
        for (int i = 0; i < N; i++) begin
            c = (start + i) % N;
            if (pick < 0 && rem[c] > 0) pick = c;
        end
        rdata = $urandom;
        rresp = 2'($urandom_range(0, 3));
        if (int'($urandom_range(0, 99)) < p_bad) begin
            rid = 4'($urandom_range(N, 15)); rvalid = 1'b1; rlast = 1'($urandom_range(0, 1));
        end else if (pick >= 0) begin
            rid = 4'(pick); rlast = (rem[pick] == 1);
            rvalid = (int'($urandom_range(0, 99)) < p_rvalid);
        end else begin
            rid = 4'($urandom_range(0, N - 1)); rlast = 1'b0; rvalid = 1'b0;
        end
    endtask

    task automatic rand_drive();
        for (int k = 0; k < N; k++) begin
            ch_arvalid[k]           = (int'($urandom_range(0, 99)) < p_req);
            ch_araddr[k*AW +: AW]   = $urandom & 32'hFFFF_FFFC;
            ch_arlen[k*4 +: 4]      = 4'($urandom_range(0, p_lenmax));
            ch_rready[k]            = (int'($urandom_range(0, 99)) < p_rready);
        end
        arready = (int'($urandom_range(0, 99)) < p_arready);
        slave_drive();
    endtask

    // One clock: compare DUT against the model at negedge, then advance the model.
    task automatic cycle();
        int win, c;
        bit rid_ok, e_rready, arhs, rhs;
        logic [N-1:0] e_arrdy, e_rv;
        @(negedge clk);
        if (rst_n) begin
            chk("rst_arvalid",   64'(arvalid_o),    64'd0);
            chk("rst_arid",      64'(arid_o),       64'd0);
            chk("rst_araddr",    64'(araddr_o),     64'd0);
            chk("rst_arlen",     64'(arlen_o),      64'd0);
            chk("rst_ch_arready",64'(ch_arready_o), 64'd0);
            chk("rst_ch_rvalid", 64'(ch_rvalid_o),  64'd0);
            chk("rst_rready",    64'(rready_o),     64'd0);
            chk("rst_id_err",    64'(id_err_o),     64'd0);
            @(posedge clk); #1;
            model_reset();
        end else begin
            rid_ok = (int'(rid) < N);
            win = -1;
            if (!m_sv || arready) begin
                for (int i = 0; i < N; i++) begin
                    c = (m_rr + i) % N;
                    if (win < 0 && ch_arvalid[c] && !m_busy[c] && !(m_sv && m_sid == c)) win = c;
                end
            end
            e_arrdy = '0;
            if (win >= 0) e_arrdy[win] = 1'b1;
            e_rv = '0; e_rready = 1'b1;
            if (rid_ok) begin
                e_rv[rid] = rvalid;
                e_rready  = ch_rready[rid];
            end
            chk("ch_arready", 64'(ch_arready_o), 64'(e_arrdy));
            chk("ch_rvalid",  64'(ch_rvalid_o),  64'(e_rv));
            chk("rready",     64'(rready_o),     64'(e_rready));
            chk("rdata",      64'(ch_rdata_o),   64'(rdata));
            chk("rresp",      64'(ch_rresp_o),   64'(rresp));
            chk("rlast",      64'(ch_rlast_o),   64'(rlast));
            chk("arvalid",    64'(arvalid_o),    64'(m_sv));
            chk("arid",       64'(arid_o),       64'(m_sid));
            chk("araddr",     64'(araddr_o),     64'(m_saddr));
            chk("arlen",      64'(arlen_o),      64'(m_slen));
            chk("arsize",     64'(arsize_o),     64'd2);
            chk("arburst",    64'(arburst_o),    64'd1);
            chk("id_err",     64'(id_err_o),     64'(m_err));
            arhs = m_sv && arready;
            rhs  = rvalid && e_rready && rid_ok;
            @(posedge clk); #1;
            if (rhs) begin
                rem[rid]--;
                if (rlast) m_busy[rid] = 1'b0;
            end
            if (arhs) begin
                m_busy[m_sid] = 1'b1;
                rem[m_sid]    = int'(m_slen) + 1;
            end
            if (rvalid && !rid_ok) m_err = 1'b1;
            if (win >= 0) begin
                m_sv    = 1'b1;
                m_sid   = win;
                m_saddr = ch_araddr[win*AW +: AW];
                m_slen  = ch_arlen[win*4 +: 4];
                m_rr    = (win + 1) % N;
            end else if (arready) begin
                m_sv = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        rand_drive();
        cycle();
        cycle();
        rst_n = 1'b0;
    endtask

    task automatic set_knobs(input int rq, input int ar, input int rv, input int rr,
                             input int bad, input int lm, input bit rnd);
        p_req = rq; p_arready = ar; p_rvalid = rv; p_rready = rr;
        p_bad = bad; p_lenmax = lm; r_rand = rnd;
    endtask

    int cnt;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b1;
        ch_arvalid = '0; ch_araddr = '0; ch_arlen = '0; ch_rready = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        model_reset();

        // single ch0 burst
        set_knobs(0, 100, 100, 100, 0, 3, 1'b0);
        do_reset();
        rand_drive();
        ch_arvalid = 4'b0001; ch_araddr[0 +: AW] = 32'h100; ch_arlen[3:0] = 4'd3;
        cycle();
        chk("t1_arvalid", 64'(arvalid_o), 64'd1);
        chk("t1_arid",    64'(arid_o),    64'd0);
        chk("t1_araddr",  64'(araddr_o),  64'h100);
        chk("t1_arlen",   64'(arlen_o),   64'd3);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            rand_drive(); #1;
            if (ch_rvalid_o == 4'b0001) cnt++;
            cycle();
        end
        chk("t1_beats", 64'(cnt), 64'd4);
        rand_drive(); ch_arvalid = 4'b0001;
        cycle();
        chk("t1_regrant", 64'({arvalid_o, arid_o}), 64'({1'b1, 4'd0}));

        // all channels continuously: grant order 0,1,2,3,0
        set_knobs(100, 100, 100, 100, 0, 0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_drive();
            cycle();
            chk("t2_arvalid", 64'(arvalid_o), 64'd1);
            chk("t2_order",   64'(arid_o),    64'(exp_order[i]));
        end

        // ch2 outstanding blocks a second AR for ch2
        set_knobs(0, 100, 0, 100, 0, 1, 1'b0);
        do_reset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rand_drive(); ch_arvalid = 4'b0100;
            cycle();
            if (arvalid_o) cnt++;
        end
        chk("t3_single_ar", 64'(cnt), 64'd1);
        p_rvalid = 100; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            rand_drive(); ch_arvalid = 4'b0100;
            cycle();
            if (arvalid_o) cnt++;
        end
        chk("t3_regrant", 64'(cnt > 0), 64'd1);

        // arready stalled 5 cycles
        set_knobs(100, 0, 0, 100, 0, 3, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rand_drive();
            for (int k = 0; k < N; k++) ch_araddr[k*AW +: AW] = 32'h1000 * (k + 1);
            cycle();
            if (i > 0) begin
                chk("t4_arvalid",  64'(arvalid_o),    64'd1);
                chk("t4_arid",     64'(arid_o),       64'd0);
                chk("t4_araddr",   64'(araddr_o),     64'h1000);
                chk("t4_ch_arrdy", 64'(ch_arready_o), 64'd0);
            end
        end

        // out-of-range rid
        set_knobs(0, 100, 0, 100, 100, 3, 1'b0);
        do_reset();
        chk("t5_err_clear", 64'(id_err_o), 64'd0);
        rand_drive(); rid = 4'd7; #1;
        chk("t5_rready",  64'(rready_o),    64'd1);
        chk("t5_rvalid",  64'(ch_rvalid_o), 64'd0);
        cycle();
        chk("t5_err_set", 64'(id_err_o), 64'd1);
        p_bad = 0;
        for (int i = 0; i < 5; i++) begin
            rand_drive();
            cycle();
        end
        chk("t5_err_sticky", 64'(id_err_o), 64'd1);

        // reset mid-burst, then fresh ch1 request
        set_knobs(100, 100, 0, 100, 0, 3, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_drive();
            cycle();
        end
        rst_n = 1'b1; #1;
        chk("t6_rst_arvalid",  64'(arvalid_o),    64'd0);
        chk("t6_rst_ch_arrdy", 64'(ch_arready_o), 64'd0);
        cycle();
        cycle();
        rst_n = 1'b0;
        p_req = 0;
        rand_drive(); ch_arvalid = 4'b0010;
        cycle();
        chk("t6_first_grant", 64'({arvalid_o, arid_o}), 64'({1'b1, 4'd1}));

        // randomized run
        set_knobs(50, 50, 50, 50, 0, 3, 1'b1);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                set_knobs(int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                          int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                          ($urandom_range(0, 9) == 0) ? 2 : 0,
                          int'($urandom_range(0, 15)), 1'b1);
            end
            if (i == 1500) begin
                do_reset();
            end
            rand_drive();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
